coin_charge_ctrl: RTL
=====================

Name: coin_charge_ctrl

Overview:
Front-end controller for the coin-operated charger. Accepts coin and confirm inputs, accumulates credit in seconds, then runs the charging session with a per-second countdown. Drives the charging enable that gates the downstream charging-time stage and the remaining-time display value. Runs on the 1000 Hz divided system clock.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per second of charge time
SEC_PER_COIN, 60, seconds of charge credited per accepted coin
MAX_SEC, 999, saturation limit for credit/remaining seconds (must fit 10 bits)
CONFIRM_TIMEOUT, 10000, clk cycles in CREDIT without confirm before auto-start
DONE_HOLD, 3000, clk cycles the done indication is held

Ports:
clk  input  1  1000 Hz clock after reduction
reset  input  1  asynchronous, active-low reset
coin  input  1  coin sensor level, asynchronous; rising edge = one coin
confirm  input  1  start button level, asynchronous; rising edge = confirm
charging  output  1  high while in CHARGE; enables the charging-time stage/relay
remain_sec  output  10  credit (CREDIT), remaining seconds (CHARGE), 0 otherwise
done  output  1  high throughout DONE
coin_ack  output  1  one-cycle pulse per accepted coin

Behaviour:
- Reset (reset low, async): state IDLE; charging=0, remain_sec=0, done=0, coin_ack=0; all counters and synchronizer flops 0.
- coin, confirm: 2-flop synchronizer + edge-detect register each; an event is sync2 & ~sync3. Credit/state update on the edge after the event: fixed 3-cycle latency from the first clk edge that samples the input high. A level held high counts once.
- States (2-bit): IDLE, CREDIT, CHARGE, DONE.
- IDLE: coin event -> remain=SEC_PER_COIN, CREDIT, timeout counter cleared. confirm ignored.
- CREDIT: coin event -> remain=min(remain+SEC_PER_COIN, MAX_SEC), timeout counter cleared. Confirm event, or timeout counter reaching CONFIRM_TIMEOUT-1 -> CHARGE, tick counter cleared. Coin and confirm in same cycle: coin is credited and state goes to CHARGE.
- CHARGE: tick counter counts 0..TICKS_PER_SEC-1 and wraps; on the wrap cycle remain decrements by 1. Coin event adds SEC_PER_COIN (saturating); with a simultaneous decrement the result is min(remain-1+SEC_PER_COIN, MAX_SEC). When the decrement takes remain to 0 with no coin that cycle -> DONE. confirm ignored.
- DONE: hold counter counts to DONE_HOLD-1, then IDLE. Coins during DONE are ignored (no coin_ack).
- Outputs are registered; charging and done follow state with no extra delay. coin_ack pulses only for credited coins, including coins clipped by saturation.
- Arithmetic: 11-bit intermediate sum before saturation to MAX_SEC; counters are sized with $clog2 of their parameter; no wrap-around of remain below 0.
- Reset asserted mid-session: immediate return to IDLE; credit is lost.

Optional Feature:
CANCEL_REFUND_EN: adds ports cancel (input, 1, async level) and refund_sec (output, 10) plus refund_valid (output, 1). A cancel event (same sync/edge path) in CREDIT or CHARGE -> IDLE next cycle; refund_valid pulses one cycle with refund_sec = remain at that cycle. Cancel takes priority over a same-cycle coin, confirm, or timeout. When the macro is undefined, these ports and logic are absent and behaviour is as above.

Test Plan:
- Reset low mid-CHARGE with remain=45 -> charging=0, remain_sec=0, state IDLE immediately, without waiting for a clk edge.
- Two coin pulses, then confirm -> coin_ack x2, remain_sec=120, charging=1; after 1000 cycles remain_sec=119.
- One coin, no confirm -> CHARGE entered exactly CONFIRM_TIMEOUT cycles after the credit update, remain_sec=60.
- 17 coins -> remain_sec saturates at 999; 17 coin_ack pulses. Coin held high 50 cycles -> counted once.
- CHARGE with remain=1; coin event on the decrement cycle -> remain_sec=60, stays CHARGE. Without the coin -> done=1 for 3000 cycles, then IDLE.
- With CANCEL_REFUND_EN: remain=75 in CHARGE, cancel -> refund_valid one cycle, refund_sec=75, IDLE, charging=0.

Source files
------------

// File: rtl/coin_charge_ctrl.sv
// rtl/coin_charge_ctrl.sv - coin credit and per-second charge countdown controller
// Optional cancel/refund path enabled by defining CANCEL_REFUND_EN.
module coin_charge_ctrl #(
   parameter int TICKS_PER_SEC   = 1000,
   parameter int SEC_PER_COIN    = 60,
   parameter int MAX_SEC         = 999,
   parameter int CONFIRM_TIMEOUT = 10000,
   parameter int DONE_HOLD       = 3000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin,
   input  logic       confirm,
`ifdef CANCEL_REFUND_EN
   input  logic       cancel,
   output logic [9:0] refund_sec,
   output logic       refund_valid,
`endif
   output logic       charging,
   output logic [9:0] remain_sec,
   output logic       done,
   output logic       coin_ack
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CREDIT = 2'd1;
   localparam logic [1:0] ST_CHARGE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam int TICK_W = $clog2(TICKS_PER_SEC);
   localparam int TMO_W  = $clog2(CONFIRM_TIMEOUT);
   localparam int HOLD_W = $clog2(DONE_HOLD);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(CONFIRM_TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);
   localparam logic [10:0]       COIN11    = 11'(SEC_PER_COIN);
   localparam logic [10:0]       MAX11     = 11'(MAX_SEC);

   logic [1:0]        state, state_n;
   logic [9:0]        remain, remain_n;
   logic [TICK_W-1:0] tick, tick_n;
   logic [TMO_W-1:0]  tmo, tmo_n;
   logic [HOLD_W-1:0] hold, hold_n;
   logic              ack_n;
   logic [2:0]        coin_sh, conf_sh;
   logic              coin_ev, conf_ev, dec;
   logic [9:0]        base;
   logic [10:0]       sum;
   logic [9:0]        sat;

   // sh[0..1] synchronize, sh[2] is the previous level for edge detection
   assign coin_ev = coin_sh[1] & ~coin_sh[2];
   assign conf_ev = conf_sh[1] & ~conf_sh[2];

`ifdef CANCEL_REFUND_EN
   logic [2:0] canc_sh;
   logic       canc_ev;
   logic       refund_valid_n;
   logic [9:0] refund_sec_n;
   assign canc_ev = canc_sh[1] & ~canc_sh[2];
`endif

   assign dec  = (state == ST_CHARGE) && (tick == TICK_LAST);
   assign base = (dec && remain != 10'd0) ? remain - 10'd1 : remain;
   assign sum  = {1'b0, base} + COIN11;
   assign sat  = (sum > MAX11) ? MAX11[9:0] : sum[9:0];

   always_comb begin
      state_n  = state;
      remain_n = remain;
      tick_n   = tick;
      tmo_n    = tmo;
      hold_n   = hold;
      ack_n    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (coin_ev) begin
               state_n  = ST_CREDIT;
               remain_n = sat;
               tmo_n    = '0;
               ack_n    = 1'b1;
            end
         end
         ST_CREDIT: begin
            if (coin_ev) begin
               remain_n = sat;
               tmo_n    = '0;
               ack_n    = 1'b1;
            end else begin
               tmo_n = tmo + TMO_W'(1);
            end
            if (conf_ev || tmo == TMO_LAST) begin
               state_n = ST_CHARGE;
               tick_n  = '0;
            end
         end
         ST_CHARGE: begin
            tick_n = dec ? '0 : tick + TICK_W'(1);
            if (coin_ev) begin
               remain_n = sat;
               ack_n    = 1'b1;
            end else if (dec) begin
               remain_n = base;
               if (base == 10'd0) begin
                  state_n = ST_DONE;
                  hold_n  = '0;
               end
            end
         end
         default: begin
            if (hold == HOLD_LAST) begin
               state_n = ST_IDLE;
            end else begin
               hold_n = hold + HOLD_W'(1);
            end
         end
      endcase
`ifdef CANCEL_REFUND_EN
      refund_valid_n = 1'b0;
      refund_sec_n   = '0;
      // cancel overrides any coin, confirm or timeout decided above
      if (canc_ev && (state == ST_CREDIT || state == ST_CHARGE)) begin
         state_n        = ST_IDLE;
         remain_n       = '0;
         ack_n          = 1'b0;
         refund_valid_n = 1'b1;
         refund_sec_n   = remain;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         remain   <= '0;
         tick     <= '0;
         tmo      <= '0;
         hold     <= '0;
         coin_sh  <= '0;
         conf_sh  <= '0;
         charging <= 1'b0;
         done     <= 1'b0;
         coin_ack <= 1'b0;
`ifdef CANCEL_REFUND_EN
         canc_sh      <= '0;
         refund_valid <= 1'b0;
         refund_sec   <= '0;
`endif
      end else begin
         state    <= state_n;
         remain   <= remain_n;
         tick     <= tick_n;
         tmo      <= tmo_n;
         hold     <= hold_n;
         coin_sh  <= {coin_sh[1:0], coin};
         conf_sh  <= {conf_sh[1:0], confirm};
         charging <= (state_n == ST_CHARGE);
         done     <= (state_n == ST_DONE);
         coin_ack <= ack_n;
`ifdef CANCEL_REFUND_EN
         canc_sh      <= {canc_sh[1:0], cancel};
         refund_valid <= refund_valid_n;
         refund_sec   <= refund_sec_n;
`endif
      end
   end

   assign remain_sec = remain;

endmodule
